// File: rtl/pu_seq_if.sv
// Host/decoder control bundle for the processing-unit sequencer.
// slave = sequencer side, master = host/decoder side.
interface pu_seq_if #(parameter int CNTW = 16);
  logic            run;
  logic            step;
  logic            halt_req;
  logic            dec_h;
  logic            dec_we;
  logic            ir_le;
  logic            pc_en;
  logic            rf_we;
  logic [2:0]      st;
  logic            busy;
  logic            halted;
  logic            step_ack;
  logic [CNTW-1:0] retired;
  logic [CNTW-1:0] cycles;

  modport slave (
    input  run, step, halt_req, dec_h, dec_we,
    output ir_le, pc_en, rf_we, st, busy, halted, step_ack, retired, cycles
  );

  modport master (
    output run, step, halt_req, dec_h, dec_we,
    input  ir_le, pc_en, rf_we, st, busy, halted, step_ack, retired, cycles
  );
endinterface

// File: rtl/pu_seq.sv
// Multi-cycle FETCH/EXEC/WB sequencer with host run/step/halt control
// and retired-instruction / active-cycle counters.
module pu_seq #(
  parameter int CNTW = 16
) (
  input  logic    clk,
  input  logic    rst,
  pu_seq_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_EXEC  = 3'd2,
    S_WB    = 3'd3,
    S_HALT  = 3'd4
  } state_t;

  state_t          r_state, w_next;
  logic            r_ss, w_ss_nxt;
  logic            r_ack, w_ack_nxt;
  logic [CNTW-1:0] r_retired, r_cycles;
  logic            w_busy, w_wb;

  assign w_busy = (r_state == S_FETCH) || (r_state == S_EXEC) || (r_state == S_WB);
  assign w_wb   = (r_state == S_WB);

  always_comb begin
    w_next    = r_state;
    w_ss_nxt  = r_ss;
    w_ack_nxt = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.step) begin
          w_next   = S_FETCH;
          w_ss_nxt = 1'b1;
        end else if (bus.run && !bus.halt_req) begin
          w_next   = S_FETCH;
          w_ss_nxt = 1'b0;
        end
      end
      S_FETCH: w_next = S_EXEC;
      S_EXEC:  w_next = S_WB;
      S_WB: begin
        if (bus.dec_h) begin
          w_next = S_HALT;
        end else if (r_ss) begin
          w_next    = S_IDLE;
          w_ss_nxt  = 1'b0;
          w_ack_nxt = 1'b1;
        end else if (bus.halt_req || !bus.run) begin
          w_next = S_IDLE;
        end else begin
          w_next = S_FETCH;
        end
      end
      S_HALT:  w_next = S_HALT;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_ss      <= 1'b0;
      r_ack     <= 1'b0;
      r_retired <= '0;
      r_cycles  <= '0;
    end else begin
      r_state <= w_next;
      r_ss    <= w_ss_nxt;
      r_ack   <= w_ack_nxt;
      if (w_wb)   r_retired <= r_retired + 1'b1;
      if (w_busy) r_cycles  <= r_cycles + 1'b1;
    end
  end

  // rst gates the write strobes so an aborted WB never commits
  assign bus.ir_le    = (r_state == S_FETCH);
  assign bus.rf_we    = w_wb && bus.dec_we && !rst;
  assign bus.pc_en    = w_wb && !bus.dec_h && !rst;
  assign bus.st       = r_state;
  assign bus.busy     = w_busy;
  assign bus.halted   = (r_state == S_HALT);
  assign bus.step_ack = r_ack;
  assign bus.retired  = r_retired;
  assign bus.cycles   = r_cycles;

endmodule

// File: tb/tb_pu_seq.sv
// Directed bench for pu_seq: per-cycle expectations queued as stimulus is
// driven, popped and checked one cycle later; a CNTW=4 copy checks wrap.
module tb_pu_seq;
  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc   = 0;

  pu_seq_if #(.CNTW(16)) bus ();
  pu_seq_if #(.CNTW(4))  bus4 ();

  pu_seq #(.CNTW(16)) u_dut  (.clk(clk), .rst(rst), .bus(bus.slave));
  pu_seq #(.CNTW(4))  u_dut4 (.clk(clk), .rst(rst), .bus(bus4.slave));

  assign bus4.run      = bus.run;
  assign bus4.step     = bus.step;
  assign bus4.halt_req = bus.halt_req;
  assign bus4.dec_h    = bus.dec_h;
  assign bus4.dec_we   = bus.dec_we;

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] st;
    logic       pc;
    logic       rf;
    logic       ack;
  } exp_t;

  exp_t q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp_v);
    end
  endtask

  task automatic push(input logic [2:0] st, input logic pc, input logic rf, input logic ack);
    exp_t e;
    e.st = st; e.pc = pc; e.rf = rf; e.ack = ack;
    q.push_back(e);
  endtask

  task automatic go(input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      cyc++;
      if (q.size() == 0) begin
        n_cmp++;
        n_err++;
        $error("FAIL scoreboard_empty cyc=%0d observed=0 expected=1", cyc);
      end else begin
        e = q.pop_front();
        chk("st",       32'(bus.st),       32'(e.st));
        chk("pc_en",    32'(bus.pc_en),    32'(e.pc));
        chk("rf_we",    32'(bus.rf_we),    32'(e.rf));
        chk("step_ack", 32'(bus.step_ack), 32'(e.ack));
        chk("ir_le",    32'(bus.ir_le),    32'(e.st == 3'd1));
        chk("busy",     32'(bus.busy),     32'(e.st >= 3'd1 && e.st <= 3'd3));
        chk("halted",   32'(bus.halted),   32'(e.st == 3'd4));
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    push(3'd0, 1'b0, 1'b0, 1'b0);
    go(1);
    rst = 1'b0;
  endtask

  initial begin
    rst          = 1'b1;
    bus.run      = 1'b0;
    bus.step     = 1'b0;
    bus.halt_req = 1'b0;
    bus.dec_h    = 1'b0;
    bus.dec_we   = 1'b0;

    // reset for two cycles, then idle for ten
    push(3'd0, 1'b0, 1'b0, 1'b0);
    push(3'd0, 1'b0, 1'b0, 1'b0);
    go(2);
    rst = 1'b0;
    repeat (10) push(3'd0, 1'b0, 1'b0, 1'b0);
    go(10);
    chk("reset_retired", 32'(bus.retired), 32'd0);
    chk("reset_cycles",  32'(bus.cycles),  32'd0);

    // single step with register write
    bus.dec_we = 1'b1;
    bus.step   = 1'b1;
    push(3'd1, 1'b0, 1'b0, 1'b0);
    go(1);
    bus.step = 1'b0;
    push(3'd2, 1'b0, 1'b0, 1'b0);
    push(3'd3, 1'b1, 1'b1, 1'b0);
    push(3'd0, 1'b0, 1'b0, 1'b1);
    push(3'd0, 1'b0, 1'b0, 1'b0);
    go(4);
    chk("step_retired", 32'(bus.retired), 32'd1);
    chk("step_cycles",  32'(bus.cycles),  32'd3);

    // continuous run, 10 instructions; a stray step mid-run is ignored
    do_reset();
    bus.dec_we = 1'b0;
    bus.run    = 1'b1;
    for (int i = 0; i < 30; i++) begin
      case (i % 3)
        0: push(3'd1, 1'b0, 1'b0, 1'b0);
        1: push(3'd2, 1'b0, 1'b0, 1'b0);
        default: push(3'd3, 1'b1, 1'b0, 1'b0);
      endcase
      bus.step = (i == 4);
      go(1);
    end
    bus.step = 1'b0;
    bus.run  = 1'b0;
    push(3'd0, 1'b0, 1'b0, 1'b0);
    go(1);
    chk("run_retired", 32'(bus.retired), 32'd10);
    chk("run_cycles",  32'(bus.cycles),  32'd30);

    // halt_req raised in EXEC lets WB finish, then holds IDLE
    do_reset();
    bus.run = 1'b1;
    push(3'd1, 1'b0, 1'b0, 1'b0);
    push(3'd2, 1'b0, 1'b0, 1'b0);
    go(2);
    bus.halt_req = 1'b1;
    push(3'd3, 1'b1, 1'b0, 1'b0);
    repeat (4) push(3'd0, 1'b0, 1'b0, 1'b0);
    go(5);
    chk("hreq_retired", 32'(bus.retired), 32'd1);
    bus.halt_req = 1'b0;
    bus.run      = 1'b0;

    // halt instruction: writes, no PC advance, sticky HALT
    do_reset();
    bus.run    = 1'b1;
    bus.dec_h  = 1'b1;
    bus.dec_we = 1'b1;
    push(3'd1, 1'b0, 1'b0, 1'b0);
    push(3'd2, 1'b0, 1'b0, 1'b0);
    push(3'd3, 1'b0, 1'b1, 1'b0);
    push(3'd4, 1'b0, 1'b0, 1'b0);
    go(4);
    for (int i = 0; i < 20; i++) begin
      bus.run  = i[0];
      bus.step = i[1];
      push(3'd4, 1'b0, 1'b0, 1'b0);
      go(1);
    end
    bus.step = 1'b0;
    bus.run  = 1'b0;
    chk("halt_retired", 32'(bus.retired), 32'd1);
    do_reset();
    bus.dec_h  = 1'b0;
    chk("halt_exit_retired", 32'(bus.retired), 32'd0);

    // rst in EXEC aborts with no write/PC pulse
    bus.run = 1'b1;
    push(3'd1, 1'b0, 1'b0, 1'b0);
    push(3'd2, 1'b0, 1'b0, 1'b0);
    go(2);
    bus.run = 1'b0;
    do_reset();
    push(3'd0, 1'b0, 1'b0, 1'b0);
    push(3'd0, 1'b0, 1'b0, 1'b0);
    go(2);
    chk("abort_retired", 32'(bus.retired), 32'd0);

    // rst in WB suppresses strobes in that same cycle
    bus.run = 1'b1;
    push(3'd1, 1'b0, 1'b0, 1'b0);
    push(3'd2, 1'b0, 1'b0, 1'b0);
    push(3'd3, 1'b1, 1'b1, 1'b0);
    go(3);
    bus.run = 1'b0;
    rst = 1'b1;
    #1;
    chk("rst_wb_rf_we", 32'(bus.rf_we), 32'd0);
    chk("rst_wb_pc_en", 32'(bus.pc_en), 32'd0);
    push(3'd0, 1'b0, 1'b0, 1'b0);
    go(1);
    rst = 1'b0;
    chk("rst_wb_retired", 32'(bus.retired), 32'd0);

    // step and run together: step wins, one instruction then IDLE
    bus.dec_we = 1'b0;
    bus.step   = 1'b1;
    bus.run    = 1'b1;
    push(3'd1, 1'b0, 1'b0, 1'b0);
    go(1);
    bus.step = 1'b0;
    bus.run  = 1'b0;
    push(3'd2, 1'b0, 1'b0, 1'b0);
    push(3'd3, 1'b1, 1'b0, 1'b0);
    push(3'd0, 1'b0, 1'b0, 1'b1);
    push(3'd0, 1'b0, 1'b0, 1'b0);
    go(4);
    chk("both_retired", 32'(bus.retired), 32'd1);

    // 16 single steps: CNTW=4 counters wrap to 0
    do_reset();
    for (int i = 0; i < 16; i++) begin
      bus.step = 1'b1;
      push(3'd1, 1'b0, 1'b0, 1'b0);
      go(1);
      bus.step = 1'b0;
      push(3'd2, 1'b0, 1'b0, 1'b0);
      push(3'd3, 1'b1, 1'b0, 1'b0);
      push(3'd0, 1'b0, 1'b0, 1'b1);
      go(3);
    end
    chk("wrap_retired16", 32'(bus.retired),  32'd16);
    chk("wrap_cycles16",  32'(bus.cycles),   32'd48);
    chk("wrap_retired4",  32'(bus4.retired), 32'd0);
    chk("wrap_cycles4",   32'(bus4.cycles),  32'd0);
    chk("scoreboard_drained", 32'(q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
